stopwatch_ctrl: RTL

//  Sequencing controller for the stopwatch counter/display datapath. Takes
//  raw start/stop/inc push-buttons, synchronises and debounces them, runs the

---
 rtl/stopwatch_ctrl_if.sv | 14 +
 rtl/stopwatch_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and datapath control outputs of the stopwatch sequencer.
// master = button/board side, slave = the controller.
interface stopwatch_ctrl_if;
  logic       start;
  logic       stop;
  logic       inc;
  logic       run;
  logic       incr;
  logic       clear;
  logic [1:0] state;

  modport master (output start, stop, inc, input run, incr, clear, state);
  modport slave  (input start, stop, inc, output run, incr, clear, state);
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: synchronise and debounce buttons, run IDLE/RUNNING/PAUSED,
// and generate the centisecond time base for the counter datapath.
module stopwatch_ctrl #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clock,
  input  logic             reset,
  stopwatch_ctrl_if.slave  bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
      $error("stopwatch_ctrl: DEBOUNCE_CYCLES must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } state_t;

  // Bit 0 start, bit 1 stop, bit 2 inc
  logic [2:0]    btn;
  logic [2:0]    sync_p0, sync_p1;
  logic [2:0]    lvl_p2, lvl_d_p3, press_p3;
  logic [CW-1:0] cnt_p2 [3];

  assign btn = {bus.inc, bus.stop, bus.start};

  // Stages p0/p1: two-flop synchroniser; p2: debounce; p3: rising-edge press pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      lvl_p2   <= '0;
      lvl_d_p3 <= '0;
      press_p3 <= '0;
      for (int i = 0; i < 3; i++) cnt_p2[i] <= '0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] == lvl_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_p2[i] <= '0;
          lvl_p2[i] <= sync_p1[i];
        end else begin
          cnt_p2[i] <= cnt_p2[i] + 1'b1;
        end
      end
      lvl_d_p3 <= lvl_p2;
      press_p3 <= lvl_p2 & ~lvl_d_p3;
    end
  end

  logic          p_start, p_stop, p_inc;
  logic          wrap;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          run_q, run_d;
  logic          incr_q, incr_d;
  logic          clear_q, clear_d;

  assign p_start = press_p3[0];
  assign p_stop  = press_p3[1];
  assign p_inc   = press_p3[2];
  assign wrap    = (presc_q == PW'(DIV - 1));

  // Stage p4: FSM and prescaler; all outputs come straight from these flops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      run_q   <= 1'b0;
      incr_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      run_q   <= run_d;
      incr_q  <= incr_d;
      clear_q <= clear_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    incr_d  = 1'b0;
    clear_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (p_start) begin
          state_d = RUNNING;
          presc_d = '0;
        end else if (p_inc) begin
          incr_d = 1'b1;
        end
      end
      RUNNING: begin
        // The tick is emitted even when a stop lands on the wrap cycle
        presc_d = wrap ? '0 : presc_q + 1'b1;
        incr_d  = wrap;
        if (p_stop) state_d = PAUSED;
      end
      PAUSED: begin
        if (p_stop) begin
          state_d = IDLE;
          clear_d = 1'b1;
          presc_d = '0;
        end else if (p_start) begin
          state_d = RUNNING;
        end else if (p_inc) begin
          incr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    run_d = (state_d == RUNNING);
  end

  assign bus.run   = run_q;
  assign bus.incr  = incr_q;
  assign bus.clear = clear_q;
  assign bus.state = state_q;

endmodule
